alu_share_sched: RTL and testbench
==================================

// Module: alu_share_sched
// PURPOSE
//  Time-shares the single ALU instance between NUM_REQ requesters (e.g. test agents, microcode units).
//  - Round-robin arbitration; one operation in flight.
//  - Drives the ALU A/B/Op inputs and returns R to the granted requester with a response pulse.
//  - Sits between the requesters and the ALU. The ALU's own reset stays on the system reset.
// PARAMETERS
//  NUM_REQ   4   number of requesters (2..8)
//  DATA_W    8   width of A, B, R
//  OP_W      3   width of Op
//  ALU_LAT   1   cycles from ALU inputs stable to R valid (>=1)
//  CNT_W     16  width of the completed-operation counter
// PORTS
//  clk        in   1               system clock, rising edge
//  reset      in   1               asynchronous, active-high reset
//  req_valid  in   NUM_REQ         request pending per requester
//  req_a      in   NUM_REQ*DATA_W  operand A, slice i = requester i
//  req_b      in   NUM_REQ*DATA_W  operand B, slice i
//  req_op     in   NUM_REQ*OP_W    opcode, slice i
//  req_ready  out  NUM_REQ         accept pulse, one-hot, one cycle
//  rsp_valid  out  NUM_REQ         result pulse, one-hot, one cycle
//  rsp_r      out  DATA_W          result; held until the next response
//  alu_a      out  DATA_W          to ALU A
//  alu_b      out  DATA_W          to ALU B
//  alu_op     out  OP_W            to ALU Op
//  alu_r      in   DATA_W          from ALU R
//  busy       out  1               high when the FSM is not IDLE
//  ops_done   out  CNT_W           completed operations; wraps at 2**CNT_W
// BEHAVIOUR
//  Reset (async, high): all outputs 0; FSM=IDLE; RR pointer=0; any in-flight op is dropped with no rsp_valid.
//  FSM states and transitions:
//   IDLE    -> WAIT when any req_valid is high.
//              Winner g = first set bit at or after the RR pointer, wrapping.
//              req_ready[g]=1 combinationally in that cycle.
//              At the edge: alu_a/b/op <= slice g; id <= g; cnt <= ALU_LAT; pointer <= (g+1) mod NUM_REQ.
//   WAIT    -> CAPTURE when cnt==1; otherwise cnt decrements each cycle.
//   CAPTURE -> IDLE. At the edge: rsp_r <= alu_r; rsp_valid[id] <= 1 for one cycle; ops_done++.
//  Timing: grant in cycle 0 -> rsp_valid/rsp_r in cycle ALU_LAT+2.
//   IDLE may grant in the same cycle that rsp_valid is high, so the period is ALU_LAT+2 cycles per op.
//  alu_a/b/op hold their last issued value between ops (no glitching back to 0).
//  Handshake rules:
//   - A requester holds req_valid and its operands until req_ready.
//   - Operands are sampled only at the grant edge.
//   - Dropping req_valid before grant is legal and leaves no state.
//  req_ready is high only in IDLE. Requests that arrive in WAIT or CAPTURE wait for the next IDLE.
//  A requester whose valid stays high is re-served only after every other active requester has been served once.
//  Simultaneous events: a grant in IDLE and a response from the previous op coexist without interaction.
//  ops_done wraps from 2**CNT_W-1 to 0 with no flag.
//  Assertions:
//   - req_ready and rsp_valid are each $onehot0.
//   - rsp_valid never occurs without a prior grant.
// STRUCTURE
//  alu_share_pkg: state_e {IDLE, WAIT, CAPTURE}; localparam ID_W = $clog2(NUM_REQ).
//  Sub-module rr_arbiter: req vector + pointer in -> one-hot grant and encoded index out; combinational.
//  Top level: FSM, latency counter, operand/result registers, ops_done counter.
// TESTING (ALU_LAT=1, NUM_REQ=4, DATA_W=8)
//  1. Single op: req0 A=8'h05 B=8'h03 Op=ADD at cycle 0
//     -> req_ready[0] in cycle 0, alu_a=05 in cycle 1, rsp_valid[0] and rsp_r=8'h08 in cycle 3, ops_done=1.
//  2. All four valid and held
//     -> grant order 0,1,2,3,0 at cycles 0,3,6,9,12; each rsp_valid bit matches the granted id.
//  3. Pointer wrap: pointer=3 after serving req2, then req0 and req3 valid
//     -> req3 granted first, then req0.
//  4. Reset asserted in WAIT (cycle 1)
//     -> outputs 0 immediately; no rsp_valid ever; after release, req1 is granted first under pointer=0 ordering.
//  5. Back-to-back: req1 held valid across its own response
//     -> re-grant in the same cycle as rsp_valid[1]; rsp_r updates only at the second response.
//  6. 65536 ops with CNT_W=16 -> ops_done wraps to 0.

Source files
------------

// File: rtl/alu_share_pkg.sv
// alu_share_pkg: FSM state type and arbiter index width shared by the scheduler files
package alu_share_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_e;
  localparam int NUM_REQ_MAX = 8;
  localparam int ID_W = $clog2(NUM_REQ_MAX);
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr, wrapping
module rr_arbiter
  import alu_share_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] idx,
  output logic            any
);
  logic [N-1:0]  w_rot;
  logic [ID_W:0] w_sum;
  assign w_rot = N'({req, req} >> ptr);
  // Walk offsets from far to near so the nearest set bit wins
  always_comb begin
    idx   = '0;
    w_sum = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_sum = {1'b0, ptr} + (ID_W + 1)'(k);
        idx   = (w_sum >= (ID_W + 1)'(N)) ? ID_W'(w_sum - (ID_W + 1)'(N)) : w_sum[ID_W-1:0];
      end
    end
  end
  assign any = |req;
  assign gnt = any ? N'(1) << idx : '0;
endmodule

// File: rtl/alu_share_sched.sv
// alu_share_sched: round-robin time-sharing of one ALU among NUM_REQ requesters, one op in flight
module alu_share_sched
  import alu_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int OP_W    = 3,
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_r,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [OP_W-1:0]           alu_op,
  input  logic [DATA_W-1:0]         alu_r,
  output logic                      busy,
  output logic [CNT_W-1:0]          ops_done
);
  localparam int LAT_W = $clog2(ALU_LAT + 1);
  state_e            r_state, w_next;
  logic [ID_W-1:0]   r_ptr, r_id, w_gid, w_ptr_nxt;
  logic [NUM_REQ-1:0] w_gnt;
  logic              w_any, w_issue;
  logic [LAT_W-1:0]  r_cnt;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req(req_valid),
    .ptr(r_ptr),
    .gnt(w_gnt),
    .idx(w_gid),
    .any(w_any)
  );
  assign w_ptr_nxt = (w_gid == ID_W'(NUM_REQ - 1)) ? '0 : w_gid + 1'b1;
  assign busy      = r_state != IDLE;
  // req_ready is gated by reset so every output reads 0 while reset is held
  always_comb begin
    w_issue   = (r_state == IDLE) && w_any && !reset;
    req_ready = w_issue ? w_gnt : '0;
    w_next    = (r_state == IDLE) ? (w_any ? WAIT : IDLE) :
                (r_state == WAIT) ? ((r_cnt == LAT_W'(1)) ? CAPTURE : WAIT) : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_id      <= '0;
      r_cnt     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rsp_valid <= '0;
      rsp_r     <= '0;
      ops_done  <= '0;
    end else begin
      r_state   <= w_next;
      rsp_valid <= (r_state == CAPTURE) ? NUM_REQ'(1) << r_id : '0;
      if (w_issue) begin
        alu_a  <= DATA_W'(req_a >> (DATA_W * w_gid));
        alu_b  <= DATA_W'(req_b >> (DATA_W * w_gid));
        alu_op <= OP_W'(req_op >> (OP_W * w_gid));
        r_id   <= w_gid;
        r_cnt  <= LAT_W'(ALU_LAT);
        r_ptr  <= w_ptr_nxt;
      end
      if (r_state == WAIT) r_cnt <= r_cnt - 1'b1;
      if (r_state == CAPTURE) begin
        rsp_r    <= alu_r;
        ops_done <= ops_done + 1'b1;
      end
    end
  end
  a_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
  a_rsp_onehot:   assert property (@(posedge clk) disable iff (reset) $onehot0(rsp_valid));
  a_rsp_granted:  assert property (@(posedge clk) disable iff (reset) (|rsp_valid) |-> $past(r_state == CAPTURE));
endmodule

// File: tb/tb_alu_share_sched.sv
// tb_alu_share_sched: scoreboard bench for the ALU time-sharing scheduler with a one-cycle ALU model
module tb_alu_share_sched;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid;
  logic [31:0] req_a, req_b;
  logic [11:0] req_op;
  logic [3:0]  req_ready, rsp_valid, req_ready4, rsp_valid4;
  logic [7:0]  rsp_r, alu_a, alu_b, alu_r, rsp_r4, alu_a4, alu_b4;
  logic [2:0]  alu_op, alu_op4;
  logic        busy, busy4;
  logic [15:0] ops_done;
  logic [3:0]  ops_done4;
  typedef struct packed {logic [1:0] id; logic [7:0] r;} exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  alu_share_sched dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_r(rsp_r), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_r(alu_r), .busy(busy), .ops_done(ops_done)
  );
  alu_share_sched #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .req_ready(req_ready4), .rsp_valid(rsp_valid4), .rsp_r(rsp_r4), .alu_a(alu_a4), .alu_b(alu_b4),
    .alu_op(alu_op4), .alu_r(alu_r), .busy(busy4), .ops_done(ops_done4)
  );
  function automatic logic [7:0] alu_f(logic [7:0] a, logic [7:0] b, logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      default: return a;
    endcase
  endfunction
  always @(posedge clk or posedge reset) alu_r <= reset ? 8'h00 : alu_f(alu_a, alu_b, alu_op);
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(int i, logic v, logic [7:0] a, logic [7:0] b, logic [2:0] op);
    req_valid[i] = v;
    req_a[i*8+:8] = a;
    req_b[i*8+:8] = b;
    req_op[i*3+:3] = op;
  endtask
  task automatic push(int i);
    exp_t e;
    e.id = 2'(i);
    e.r = alu_f(req_a[i*8+:8], req_b[i*8+:8], req_op[i*3+:3]);
    q.push_back(e);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    q.delete();
    cyc();
    cyc();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    req_valid = '0; req_a = '0; req_b = '0; req_op = '0; reset = 1'b1;
    cyc();
    cyc();
    checks++;
    if ({req_ready, rsp_valid, busy} !== '0) begin
      failures++; $display("FAIL reset_ctrl got=%b required=0", {req_ready, rsp_valid, busy});
    end
    checks++;
    if ({rsp_r, alu_a, alu_b, alu_op} !== '0) begin
      failures++; $display("FAIL reset_data got=%h required=0", {rsp_r, alu_a, alu_b, alu_op});
    end
    checks++;
    if (ops_done !== 16'd0) begin
      failures++; $display("FAIL reset_ops got=%0d required=0", ops_done);
    end
    req_valid = 4'hF;
    #1;
    checks++;
    if (req_ready !== 4'b0) begin
      failures++; $display("FAIL reset_ready got=%b required=0000", req_ready);
    end
    req_valid = '0;
    cyc();
    reset = 1'b0;
  endtask
  task automatic test_single();
    logic [3:0] exp_g;
    for (int c = 0; c <= 5; c++) begin
      cyc();
      if (c == 0) begin set_req(0, 1'b1, 8'h05, 8'h03, 3'd0); push(0); end
      if (c == 1) req_valid[0] = 1'b0;
      #1;
      exp_g = (c == 0) ? 4'b0001 : 4'b0000;
      checks++;
      if (req_ready !== exp_g) begin
        failures++; $display("FAIL single_ready c=%0d got=%b required=%b", c, req_ready, exp_g);
      end
      if (c == 1) begin
        checks++;
        if ({alu_a, alu_b, alu_op, busy} !== {8'h05, 8'h03, 3'd0, 1'b1}) begin
          failures++; $display("FAIL single_issue got a=%h b=%h op=%0d busy=%b required a=05 b=03 op=0 busy=1", alu_a, alu_b, alu_op, busy);
        end
      end
      if (c == 3) begin
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_r !== 8'h08 || ops_done !== 16'd1) begin
          failures++; $display("FAIL single_rsp got v=%b r=%h ops=%0d required v=0001 r=08 ops=1", rsp_valid, rsp_r, ops_done);
        end
      end
      if (c == 5) begin
        checks++;
        if (rsp_valid !== 4'b0 || rsp_r !== 8'h08 || busy !== 1'b0) begin
          failures++; $display("FAIL single_hold got v=%b r=%h busy=%b required v=0000 r=08 busy=0", rsp_valid, rsp_r, busy);
        end
      end
      if (rsp_valid !== '0) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL single_sb got rsp_valid=%b required no response", rsp_valid);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (rsp_valid !== 4'(1 << e.id) || rsp_r !== e.r) begin
            failures++; $display("FAIL single_sb got v=%b r=%h required id=%0d r=%h", rsp_valid, rsp_r, e.id, e.r);
          end
        end
      end
    end
  endtask
  task automatic test_all_held();
    logic [3:0] exp_g, exp_v;
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      cyc();
      if (c == 0) for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'(8'h36 + i), 8'(8'h07 + i), 3'(i));
      if (c == 1) set_req(0, 1'b1, 8'hF0, 8'h20, 3'd1);
      if (c == 13) req_valid = '0;
      #1;
      exp_g = (c % 3 == 0 && c <= 12) ? 4'(1 << ((c / 3) % 4)) : 4'b0;
      exp_v = (c % 3 == 0 && c >= 3 && c <= 15) ? 4'(1 << ((c / 3 - 1) % 4)) : 4'b0;
      checks++;
      if (req_ready !== exp_g) begin
        failures++; $display("FAIL all_ready c=%0d got=%b required=%b", c, req_ready, exp_g);
      end
      if (exp_g != 4'b0) push((c / 3) % 4);
      checks++;
      if (rsp_valid !== exp_v) begin
        failures++; $display("FAIL all_rsp c=%0d got=%b required=%b", c, rsp_valid, exp_v);
      end
      if (rsp_valid !== '0) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL all_sb got rsp_valid=%b required no response", rsp_valid);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (rsp_valid !== 4'(1 << e.id) || rsp_r !== e.r) begin
            failures++; $display("FAIL all_sb got v=%b r=%h required id=%0d r=%h", rsp_valid, rsp_r, e.id, e.r);
          end
        end
      end
    end
  endtask
  task automatic test_ptr_wrap();
    logic [3:0] exp_g;
    for (int c = 0; c <= 9; c++) begin
      cyc();
      if (c == 0) set_req(2, 1'b1, 8'h0F, 8'h3C, 3'd2);
      if (c == 1) begin
        req_valid[2] = 1'b0;
        set_req(0, 1'b1, 8'h55, 8'h0A, 3'd3);
        set_req(3, 1'b1, 8'h81, 8'h02, 3'd1);
      end
      if (c == 4) req_valid[3] = 1'b0;
      if (c == 7) req_valid[0] = 1'b0;
      #1;
      exp_g = (c == 0) ? 4'b0100 : (c == 3) ? 4'b1000 : (c == 6) ? 4'b0001 : 4'b0000;
      checks++;
      if (req_ready !== exp_g) begin
        failures++; $display("FAIL wrap_ready c=%0d got=%b required=%b", c, req_ready, exp_g);
      end
      if (exp_g != 4'b0) push((c == 0) ? 2 : (c == 3) ? 3 : 0);
      if (rsp_valid !== '0) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL wrap_sb got rsp_valid=%b required no response", rsp_valid);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (rsp_valid !== 4'(1 << e.id) || rsp_r !== e.r) begin
            failures++; $display("FAIL wrap_sb got v=%b r=%h required id=%0d r=%h", rsp_valid, rsp_r, e.id, e.r);
          end
        end
      end
    end
  endtask
  task automatic test_reset_in_wait();
    logic [3:0] exp_g, exp_v;
    for (int c = 0; c <= 10; c++) begin
      cyc();
      if (c == 0) begin
        set_req(1, 1'b1, 8'hA5, 8'h5A, 3'd4);
        set_req(3, 1'b1, 8'h33, 8'h11, 3'd0);
      end
      if (c == 1) reset = 1'b1;
      if (c == 3) reset = 1'b0;
      if (c == 4) req_valid[1] = 1'b0;
      if (c == 7) req_valid[3] = 1'b0;
      #1;
      exp_g = (c == 0 || c == 3) ? 4'b0010 : (c == 6) ? 4'b1000 : 4'b0000;
      exp_v = (c == 6) ? 4'b0010 : (c == 9) ? 4'b1000 : 4'b0000;
      checks++;
      if (req_ready !== exp_g) begin
        failures++; $display("FAIL rstwait_ready c=%0d got=%b required=%b", c, req_ready, exp_g);
      end
      if (c == 3 || c == 6) push((c == 3) ? 1 : 3);
      checks++;
      if (rsp_valid !== exp_v) begin
        failures++; $display("FAIL rstwait_rsp c=%0d got=%b required=%b", c, rsp_valid, exp_v);
      end
      if (c == 1) begin
        checks++;
        if ({alu_a, alu_b, alu_op, rsp_r, ops_done, busy} !== '0) begin
          failures++; $display("FAIL rstwait_zero got a=%h b=%h op=%0d r=%h ops=%0d busy=%b required all 0", alu_a, alu_b, alu_op, rsp_r, ops_done, busy);
        end
      end
      if (c == 6) begin
        checks++;
        if (ops_done !== 16'd1) begin
          failures++; $display("FAIL rstwait_ops got=%0d required=1", ops_done);
        end
      end
      if (rsp_valid !== '0) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL rstwait_sb got rsp_valid=%b required no response", rsp_valid);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (rsp_valid !== 4'(1 << e.id) || rsp_r !== e.r) begin
            failures++; $display("FAIL rstwait_sb got v=%b r=%h required id=%0d r=%h", rsp_valid, rsp_r, e.id, e.r);
          end
        end
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [3:0] exp_g, exp_v;
    for (int c = 0; c <= 7; c++) begin
      cyc();
      if (c == 0) set_req(1, 1'b1, 8'h40, 8'h02, 3'd0);
      if (c == 1) set_req(1, 1'b1, 8'h90, 8'h10, 3'd1);
      if (c == 4) req_valid[1] = 1'b0;
      #1;
      exp_g = (c == 0 || c == 3) ? 4'b0010 : 4'b0000;
      exp_v = (c == 3 || c == 6) ? 4'b0010 : 4'b0000;
      checks++;
      if (req_ready !== exp_g || rsp_valid !== exp_v) begin
        failures++; $display("FAIL b2b_hs c=%0d got rdy=%b v=%b required rdy=%b v=%b", c, req_ready, rsp_valid, exp_g, exp_v);
      end
      if (exp_g != 4'b0) push(1);
      if (c >= 3) begin
        checks++;
        if (rsp_r !== ((c >= 6) ? 8'h80 : 8'h42)) begin
          failures++; $display("FAIL b2b_r c=%0d got=%h required=%h", c, rsp_r, (c >= 6) ? 8'h80 : 8'h42);
        end
      end
      if (rsp_valid !== '0) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL b2b_sb got rsp_valid=%b required no response", rsp_valid);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (rsp_valid !== 4'(1 << e.id) || rsp_r !== e.r) begin
            failures++; $display("FAIL b2b_sb got v=%b r=%h required id=%0d r=%h", rsp_valid, rsp_r, e.id, e.r);
          end
        end
      end
    end
  endtask
  task automatic test_ops_wrap();
    logic [3:0] exp_g;
    do_reset();
    for (int c = 0; c <= 50; c++) begin
      cyc();
      if (c == 0) set_req(2, 1'b1, 8'h11, 8'h22, 3'd4);
      if (c == 46) req_valid[2] = 1'b0;
      #1;
      exp_g = (c % 3 == 0 && c <= 45) ? 4'b0100 : 4'b0000;
      checks++;
      if (req_ready !== exp_g) begin
        failures++; $display("FAIL opswrap_ready c=%0d got=%b required=%b", c, req_ready, exp_g);
      end
      if (exp_g != 4'b0) push(2);
      if (c == 45) begin
        checks++;
        if (ops_done4 !== 4'd15 || ops_done !== 16'd15) begin
          failures++; $display("FAIL opswrap_pre got small=%0d wide=%0d required 15 15", ops_done4, ops_done);
        end
      end
      if (c == 48) begin
        checks++;
        if (ops_done4 !== 4'd0 || ops_done !== 16'd16) begin
          failures++; $display("FAIL opswrap_post got small=%0d wide=%0d required 0 16", ops_done4, ops_done);
        end
        checks++;
        if ({req_ready4, rsp_valid4, rsp_r4, alu_a4, alu_b4, alu_op4, busy4} !== {req_ready, rsp_valid, rsp_r, alu_a, alu_b, alu_op, busy}) begin
          failures++; $display("FAIL opswrap_twin got r=%h a=%h required r=%h a=%h", rsp_r4, alu_a4, rsp_r, alu_a);
        end
      end
      if (rsp_valid !== '0) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL opswrap_sb got rsp_valid=%b required no response", rsp_valid);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (rsp_valid !== 4'(1 << e.id) || rsp_r !== e.r) begin
            failures++; $display("FAIL opswrap_sb got v=%b r=%h required id=%0d r=%h", rsp_valid, rsp_r, e.id, e.r);
          end
        end
      end
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    test_reset();
    test_single();
    test_all_held();
    test_ptr_wrap();
    test_reset_in_wait();
    test_back_to_back();
    test_ops_wrap();
    checks++;
    if (q.size() != 0) begin
      failures++; $display("FAIL sb_drain got pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
